// File: rtl/prescaled_timer.sv
// Programmable down-counter clocked by rising edges of a prescaler wave sampled on clk.
// Optional sticky interrupt when PRESCALED_TIMER_IRQ_STICKY_EN is defined.
module prescaled_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_val,
`ifdef PRESCALED_TIMER_IRQ_STICKY_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tick_prev;
  logic             tick_rise;
  logic             done_d, err_d, busy_d;

  assign tick_rise = tick_in & ~tick_prev;

  // Handshake: start/stop/clear are level requests sampled each clk edge,
  // resolved in priority order clear > stop > start > tick_rise.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (stop && state_q == S_RUN) begin
      state_d = S_PAUSE;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      if (load_val != '0) begin
        count_d  = load_val;
        reload_d = load_val;
        mode_d   = periodic;
        state_d  = S_RUN;
      end else begin
        err_d = 1'b1;
      end
    end else if (start && state_q == S_PAUSE) begin
      state_d = S_RUN;
    end else if (tick_rise && state_q == S_RUN) begin
      if (count > WIDTH'(1)) begin
        count_d = count - WIDTH'(1);
      end else begin
        count_d = mode_q ? reload_q : '0;
        done_d  = 1'b1;
        if (!mode_q) state_d = S_DONE;
      end
    end
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count     <= '0;
      reload_q  <= '0;
      mode_q    <= 1'b0;
      tick_prev <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      count     <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      tick_prev <= tick_in;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

`ifdef PRESCALED_TIMER_IRQ_STICKY_EN
  // A done pulse sets irq even if irq_clr is high in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= done | (irq & ~irq_clr);
  end
`endif

endmodule

// File: tb/tb_prescaled_timer.sv
// Directed bench for prescaled_timer: one-shot, periodic, pause/resume, boundaries, priority, reset.
module tb_prescaled_timer;

  logic       clk;
  logic       rst_n;
  logic       tick_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic       periodic;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       err;
`ifdef PRESCALED_TIMER_IRQ_STICKY_EN
  logic       irq_clr;
  logic       irq;
`endif

  int checks   = 0;
  int failures = 0;

  prescaled_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .periodic (periodic),
    .load_val (load_val),
`ifdef PRESCALED_TIMER_IRQ_STICKY_EN
    .irq_clr  (irq_clr),
    .irq      (irq),
`endif
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One tick_in period (2 clk high, 2 clk low); checks right after the rising edge.
  task automatic do_rise(input string tag, input int exp_count, input int exp_done);
    tick_in = 1'b1;
    step();
    chk({tag, "_count"}, int'(count), exp_count);
    chk({tag, "_done"}, int'(done), exp_done);
    step();
    tick_in = 1'b0;
    step();
    step();
  endtask

  task automatic do_start(input int lv, input logic per);
    load_val = 8'(lv);
    periodic = per;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    periodic = 1'b0; load_val = '0;
`ifdef PRESCALED_TIMER_IRQ_STICKY_EN
    irq_clr = 1'b0;
`endif
    repeat (3) step();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    step();

    // one-shot, load 3
    do_start(3, 1'b0);
    chk("os_load_count", int'(count), 3);
    chk("os_load_busy", int'(busy), 1);
    do_rise("os_r1", 2, 0);
    do_rise("os_r2", 1, 0);
    do_rise("os_r3", 0, 1);
    chk("os_busy_after", int'(busy), 0);
    chk("os_done_gone", int'(done), 0);
    do_rise("os_r4", 0, 0);

    // periodic, load 2
    do_start(2, 1'b1);
    chk("per_load_count", int'(count), 2);
    do_rise("per_r1", 1, 0);
    do_rise("per_r2", 2, 1);
    do_rise("per_r3", 1, 0);
    do_rise("per_r4", 2, 1);
    chk("per_busy", int'(busy), 1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("per_clear_count", int'(count), 0);
    chk("per_clear_busy", int'(busy), 0);

    // pause / resume, load 6
    do_start(6, 1'b0);
    do_rise("pr_r1", 5, 0);
    do_rise("pr_r2", 4, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("pr_pause_busy", int'(busy), 1);
    do_rise("pr_p1", 4, 0);
    do_rise("pr_p2", 4, 0);
    do_rise("pr_p3", 4, 0);
    load_val = 8'd6; periodic = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("pr_resume_count", int'(count), 4);
    do_rise("pr_r3", 3, 0);
    // stop coinciding with a tick edge drops the edge
    tick_in = 1'b1; stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pr_stop_edge_count", int'(count), 3);
    step(); tick_in = 1'b0; step(); step();
    start = 1'b1; step(); start = 1'b0;
    do_rise("pr_r4", 2, 0);
    do_rise("pr_r5", 1, 0);
    // resumed run keeps the one-shot mode captured at the original start
    do_rise("pr_r6", 0, 1);
    chk("pr_end_busy", int'(busy), 0);

    // zero load from DONE -> err, nothing else changes
    do_start(0, 1'b0);
    chk("z_err", int'(err), 1);
    chk("z_count", int'(count), 0);
    chk("z_busy", int'(busy), 0);
    step();
    chk("z_err_gone", int'(err), 0);

    // tick_in held high gives exactly one decrement
    do_start(5, 1'b0);
    tick_in = 1'b1;
    repeat (10) step();
    chk("hold_count", int'(count), 4);
    tick_in = 1'b0; step();

    // clear + stop + start together in RUN
    do_rise("pri_r1", 3, 0);
    clear = 1'b1; stop = 1'b1; start = 1'b1; load_val = 8'd9;
    step();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    chk("pri_count", int'(count), 0);
    chk("pri_busy", int'(busy), 0);
    chk("pri_done", int'(done), 0);
    step();
    chk("pri_done2", int'(done), 0);

`ifdef PRESCALED_TIMER_IRQ_STICKY_EN
    chk("irq_idle", int'(irq), 0);
    do_start(1, 1'b0);
    tick_in = 1'b1; step();
    chk("irq_done", int'(done), 1);
    step();
    chk("irq_set", int'(irq), 1);
    tick_in = 1'b0; step(); step();
    chk("irq_sticky", int'(irq), 1);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    chk("irq_cleared", int'(irq), 0);
    do_start(1, 1'b0);
    tick_in = 1'b1; step();
    chk("irq_done2", int'(done), 1);
    irq_clr = 1'b1; step();
    chk("irq_set_wins", int'(irq), 1);
    step(); irq_clr = 1'b0;
    chk("irq_cleared2", int'(irq), 0);
    tick_in = 1'b0; step();
`endif

    // asynchronous reset mid-run with count = 5
    do_start(5, 1'b0);
    chk("ar_count_pre", int'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", int'(count), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_count_post", int'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
